pixel_reorder_queue: RTL and testbench

Parametrised circular-buffer queue between the pixel engines and the combinator. Engines push `(x, y, colour)` results with a valid/ready handshake. The combinator presents the coordinate it needs next, and the queue pops and forwards the head entry only when its coordinates match. This block replaces the shift-register queue with pointer-based storage, explicit flow control, duplicate suppression on full `(x, y)`, flush and occupancy reporting.

---
 rtl/pixel_pkg.sv | 13 +
 rtl/pixel_queue_mem.sv | 26 ++
 rtl/pixel_reorder_queue.sv | 127 ++++++++++++
 tb/tb_pixel_reorder_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel types and widths used by the engines, the reorder queue and the combinator.
package pixel_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int RGB_SIZE   = 24;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
    logic [RGB_SIZE-1:0]   colour;
  } pixel_t;

endpackage

// File: rtl/pixel_queue_mem.sv
// Ring storage for the reorder queue: one synchronous write port, one asynchronous read port.
module pixel_queue_mem
  import pixel_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = pixel_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_data
);

  entry_t mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
  end

  // The head must be compared in the same cycle the pointer moves, so the read is unregistered.
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/pixel_reorder_queue.sv
// Circular-buffer reorder queue: engines push pixels, the combinator pops the head only when
// its coordinate matches the requested one. Consecutive duplicate (x, y) pushes are dropped.
module pixel_reorder_queue #(
  parameter int  DATA_WIDTH = pixel_pkg::DATA_WIDTH,
  parameter int  RGB_SIZE   = pixel_pkg::RGB_SIZE,
  parameter int  DEPTH      = 16,
  parameter int  AF_THRESH  = DEPTH - 2,
  parameter int  DEDUP      = 1,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_y,
  input  logic [RGB_SIZE-1:0]   in_colour,
  input  logic                  chk_valid,
  input  logic [DATA_WIDTH-1:0] chk_x,
  input  logic [DATA_WIDTH-1:0] chk_y,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [RGB_SIZE-1:0]   out_colour,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  dup_drop
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
    logic [RGB_SIZE-1:0]   colour;
  } entry_t;

  logic [AW-1:0]         wp_reg, rp_reg;
  logic [CW-1:0]         count_reg;
  logic [DATA_WIDTH-1:0] last_x_reg, last_y_reg;
  logic                  last_vld_reg;
  logic                  out_valid_reg, dup_drop_reg;
  logic [DATA_WIDTH-1:0] out_x_reg, out_y_reg;
  logic [RGB_SIZE-1:0]   out_colour_reg;

  entry_t head, wr_entry;
  logic   push_hs, is_dup, push_store, pop;

  assign empty       = (count_reg == '0);
  assign full        = (count_reg == CW'(DEPTH));
  assign almost_full = (count_reg >= CW'(AF_THRESH));
  // in_ready depends only on registered count, never on the same-cycle pop.
  assign in_ready    = !full;
  assign count       = count_reg;

  assign push_hs    = in_valid && in_ready;
  assign is_dup     = (DEDUP != 0) && last_vld_reg && (in_x == last_x_reg) && (in_y == last_y_reg);
  assign push_store = push_hs && !is_dup && !flush;
  assign pop        = chk_valid && !empty && (head.x == chk_x) && (head.y == chk_y) && !flush;

  assign wr_entry = '{x: in_x, y: in_y, colour: in_colour};

  pixel_queue_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_store && !reset),
    .wr_addr (wp_reg),
    .wr_data (wr_entry),
    .rd_addr (rp_reg),
    .rd_data (head)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp_reg        <= '0;
      rp_reg        <= '0;
      count_reg     <= '0;
      last_vld_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      dup_drop_reg  <= 1'b0;
      // Flush keeps the last popped data visible; only reset clears it.
      if (reset) begin
        last_x_reg     <= '0;
        last_y_reg     <= '0;
        out_x_reg      <= '0;
        out_y_reg      <= '0;
        out_colour_reg <= '0;
      end
    end else begin
      out_valid_reg <= pop;
      dup_drop_reg  <= push_hs && is_dup;
      if (pop) begin
        rp_reg         <= rp_reg + AW'(1);
        out_x_reg      <= head.x;
        out_y_reg      <= head.y;
        out_colour_reg <= head.colour;
      end
      if (push_store) begin
        wp_reg       <= wp_reg + AW'(1);
        last_x_reg   <= in_x;
        last_y_reg   <= in_y;
        last_vld_reg <= 1'b1;
      end
      case ({push_store, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_x      = out_x_reg;
  assign out_y      = out_y_reg;
  assign out_colour = out_colour_reg;
  assign dup_drop   = dup_drop_reg;

  // An underflowing decrement wraps far above DEPTH, so one bound covers both directions.
  always_ff @(posedge clk) begin
    if (!reset) assert (count_reg <= CW'(DEPTH));
  end

endmodule

// File: tb/tb_pixel_reorder_queue.sv
// Bench for pixel_reorder_queue: directed table, full/wrap sequences and random traffic
// checked against a queue-based reference model.
module tb_pixel_reorder_queue;

  localparam int DW    = 32;
  localparam int RW    = 24;
  localparam int DEPTH = 4;
  localparam int AF    = DEPTH - 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, chk_valid;
  logic [DW-1:0] in_x, in_y, chk_x, chk_y, out_x, out_y;
  logic [RW-1:0] in_colour, out_colour;
  logic          out_valid, empty, full, almost_full, dup_drop;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  pixel_reorder_queue #(
    .DATA_WIDTH (DW),
    .RGB_SIZE   (RW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .DEDUP      (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_colour   (in_colour),
    .chk_valid   (chk_valid),
    .chk_x       (chk_x),
    .chk_y       (chk_y),
    .out_valid   (out_valid),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_colour  (out_colour),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .dup_drop    (dup_drop)
  );

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [RW-1:0] c;
  } pix_t;

  // Reference model: an ordered list of stored pixels plus the last stored coordinate.
  pix_t          q[$];
  pix_t          m_out;
  logic          m_ov, m_dup, m_lv;
  logic [DW-1:0] m_lx, m_ly;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [DW-1:0] x, input logic [DW-1:0] y,
                      input logic [RW-1:0] c, input logic cv, input logic [DW-1:0] cx,
                      input logic [DW-1:0] cy, input logic fl);
    bit   ready, pop, push, dup;
    pix_t p;
    in_valid = iv; in_x = x; in_y = y; in_colour = c;
    chk_valid = cv; chk_x = cx; chk_y = cy; flush = fl;
    ready = (q.size() < DEPTH);
    pop   = cv && (q.size() > 0) && (q[0].x == cx) && (q[0].y == cy);
    push  = iv && ready;
    dup   = push && m_lv && (m_lx == x) && (m_ly == y);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      m_lv = 1'b0; m_ov = 1'b0; m_dup = 1'b0;
    end else begin
      m_ov  = pop;
      m_dup = dup;
      if (pop) m_out = q.pop_front();
      if (push && !dup) begin
        p.x = x; p.y = y; p.c = c;
        q.push_back(p);
        m_lx = x; m_ly = y; m_lv = 1'b1;
      end
    end
    check("count", 64'(count), 64'(q.size()));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("full", 64'(full), 64'(q.size() == DEPTH));
    check("almost_full", 64'(almost_full), 64'(q.size() >= AF));
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("dup_drop", 64'(dup_drop), 64'(m_dup));
    if (m_ov) begin
      check("out_x", 64'(out_x), 64'(m_out.x));
      check("out_y", 64'(out_y), 64'(m_out.y));
      check("out_colour", 64'(out_colour), 64'(m_out.c));
      $display("txn pop x=%0d y=%0d colour=%06h count=%0d", out_x, out_y, out_colour, count);
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic push(input int x, input int y, input int c);
    step(1'b1, DW'(x), DW'(y), RW'(c), 1'b0, '0, '0, 1'b0);
  endtask

  task automatic pop_head();
    if (q.size() > 0) step(1'b0, '0, '0, '0, 1'b1, q[0].x, q[0].y, 1'b0);
    else idle();
  endtask

  typedef struct {
    int iv, x, y, c, cv, cx, cy, fl;
    int e_ov, e_col, e_cnt, e_dup;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // iv  x   y   colour     cv cx cy fl | ov colour    cnt dup
    tbl.push_back('{1,  1,  0, 'hFF0000, 0, 0, 0, 0,  0, 0,        1, 0});
    tbl.push_back('{1,  2,  0, 'h00FF00, 0, 0, 0, 0,  0, 0,        2, 0});
    tbl.push_back('{1,  3,  0, 'h0000FF, 0, 0, 0, 0,  0, 0,        3, 0});
    tbl.push_back('{0,  0,  0, 0,        1, 1, 0, 0,  1, 'hFF0000, 2, 0});
    tbl.push_back('{0,  0,  0, 0,        0, 0, 0, 0,  0, 0,        2, 0});
    tbl.push_back('{0,  0,  0, 0,        1, 2, 0, 0,  1, 'h00FF00, 1, 0});
    tbl.push_back('{0,  0,  0, 0,        1, 3, 0, 0,  1, 'h0000FF, 0, 0});
    tbl.push_back('{1,  5,  5, 'h123456, 0, 0, 0, 0,  0, 0,        1, 0});
    tbl.push_back('{1,  5,  5, 'h123456, 0, 0, 0, 0,  0, 0,        1, 1});
    tbl.push_back('{1,  5,  6, 'h654321, 0, 0, 0, 0,  0, 0,        2, 0});
    tbl.push_back('{1,  5,  5, 'hABCDEF, 0, 0, 0, 0,  0, 0,        3, 0});
    tbl.push_back('{0,  0,  0, 0,        1, 8, 0, 0,  0, 0,        3, 0});
    tbl.push_back('{0,  0,  0, 0,        1, 8, 0, 0,  0, 0,        3, 0});
    tbl.push_back('{0,  0,  0, 0,        1, 8, 0, 0,  0, 0,        3, 0});
    tbl.push_back('{0,  0,  0, 0,        1, 5, 5, 0,  1, 'h123456, 2, 0});
    tbl.push_back('{1,  9,  9, 'h000111, 1, 5, 6, 0,  1, 'h654321, 2, 0});
    tbl.push_back('{1, 10, 10, 'h000333, 0, 0, 0, 0,  0, 0,        3, 0});
    tbl.push_back('{1, 10, 10, 'h000444, 1, 5, 5, 1,  0, 0,        0, 0});
    tbl.push_back('{1, 10, 10, 'h000555, 0, 0, 0, 0,  0, 0,        1, 0});
    tbl.push_back('{0,  0,  0, 0,        1,10,10, 0,  1, 'h000555, 0, 0});
    tbl.push_back('{0,  0,  0, 0,        1,10,10, 0,  0, 0,        0, 0});

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; chk_valid = 1'b0;
    in_x = '0; in_y = '0; in_colour = '0; chk_x = '0; chk_y = '0;
    m_ov = 1'b0; m_dup = 1'b0; m_lv = 1'b0; m_lx = '0; m_ly = '0; m_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_x", 64'(out_x), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_colour", 64'(out_colour), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_almost_full", 64'(almost_full), 64'd0);
    check("rst_dup_drop", 64'(dup_drop), 64'd0);
    reset = 1'b0;

    // Directed table: basic pops, dedup on full (x, y), mismatch hold, flush.
    foreach (tbl[i]) begin
      step(tbl[i].iv != 0, DW'(tbl[i].x), DW'(tbl[i].y), RW'(tbl[i].c),
           tbl[i].cv != 0, DW'(tbl[i].cx), DW'(tbl[i].cy), tbl[i].fl != 0);
      check($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      check($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      check($sformatf("tbl%0d_dup_drop", i), 64'(dup_drop), 64'(tbl[i].e_dup));
      check($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_cnt < DEPTH));
      if (tbl[i].e_ov != 0)
        check($sformatf("tbl%0d_colour", i), 64'(out_colour), 64'(tbl[i].e_col));
    end

    // Fill to DEPTH, refuse a fifth push, then free a slot with a pop.
    for (int k = 0; k < DEPTH; k++) push(20 + k, 1, 'h100 + k);
    check("fill_full", 64'(full), 64'd1);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    push(24, 1, 'h1FF);
    check("fill_refused_count", 64'(count), 64'(DEPTH));
    step(1'b1, DW'(24), DW'(1), RW'('h1FF), 1'b1, DW'(20), DW'(1), 1'b0);
    check("fill_pop_count", 64'(count), 64'(DEPTH - 1));
    check("fill_pop_ready", 64'(in_ready), 64'd1);
    check("fill_pop_x", 64'(out_x), 64'd20);
    while (q.size() > 0) pop_head();

    // Sustained push+pop across pointer wrap; output order must follow input order.
    push(30, 0, 'h300);
    push(31, 0, 'h301);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, DW'(32 + k), '0, RW'('h302 + k), 1'b1, q[0].x, q[0].y, 1'b0);
      check("wrap_count", 64'(count), 64'd2);
      check("wrap_order", 64'(out_x), 64'(30 + k));
    end
    while (q.size() > 0) pop_head();

    // Random traffic on a small coordinate space to provoke duplicates and matches.
    for (int n = 0; n < 400; n++) begin
      logic          iv, cv, fl;
      logic [DW-1:0] x, y, cx, cy;
      iv = ($urandom_range(0, 2) != 0);
      x  = $urandom_range(0, 3);
      y  = $urandom_range(0, 1);
      cv = ($urandom_range(0, 9) < 7);
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        cx = q[0].x; cy = q[0].y;
      end else begin
        cx = $urandom_range(0, 3); cy = $urandom_range(0, 1);
      end
      fl = ($urandom_range(0, 39) == 0);
      step(iv, x, y, RW'($urandom), cv, cx, cy, fl);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
